// File: rtl/crypto_arbiter.sv
// Two-requester arbiter sharing one crypto unit (AES32 / SM4), one operation outstanding.
// Define CRYPTO_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module crypto_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][2:0]        req_op,
  input  logic [1:0][DATA_W-1:0] req_rs1,
  input  logic [1:0][DATA_W-1:0] req_rs2,
  input  logic [1:0][1:0]        req_bs,
  input  logic [1:0]             req_flush,
  output logic [1:0]             resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   unit_valid,
  output logic [2:0]             unit_op,
  output logic [DATA_W-1:0]      unit_rs1,
  output logic [DATA_W-1:0]      unit_rs2,
  output logic [1:0]             unit_bs,
  input  logic                   unit_busy,
  input  logic                   unit_result_valid,
  input  logic [DATA_W-1:0]      unit_result,
  output logic                   unit_flush,
  output logic [1:0]             dbg_state
);

  // op_t encoding; codes 6 and 7 are not crypto ops and bypass the unit.
  localparam logic [2:0] OP_AES32_DSI  = 3'd0;
  localparam logic [2:0] OP_AES32_DSMI = 3'd1;
  localparam logic [2:0] OP_AES32_ESI  = 3'd2;
  localparam logic [2:0] OP_AES32_ESMI = 3'd3;
  localparam logic [2:0] OP_SM4_ED     = 3'd4;
  localparam logic [2:0] OP_SM4_KS     = 3'd5;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  // Handshake: a request is transferred in a cycle where req_valid[i] and req_ready[i]
  // are both high; req_ready is one-hot or zero and only ever high in IDLE.

  logic [1:0] state_q;
  logic       owner_q;
  logic       bypass_q;
  logic       unit_valid_q;

  logic [1:0] eligible;
  logic       grant_en;
  logic       grant_id;
  logic [2:0] sel_op;
  logic       sel_is_crypto;
  logic       owner_flush;

`ifdef CRYPTO_ARB_RR_EN
  logic prio_q;
`endif

  assign eligible = req_valid & ~req_flush;
  assign grant_en = (state_q == IDLE) && !unit_busy && (eligible != 2'b00);

  always_comb begin
    grant_id = 1'b0;
`ifdef CRYPTO_ARB_RR_EN
    if (eligible == 2'b11) grant_id = prio_q;
    else                   grant_id = eligible[1];
`else
    grant_id = !eligible[0];
`endif
  end

  assign sel_op        = req_op[grant_id];
  assign sel_is_crypto = (sel_op == OP_AES32_DSI)  || (sel_op == OP_AES32_DSMI) ||
                         (sel_op == OP_AES32_ESI)  || (sel_op == OP_AES32_ESMI) ||
                         (sel_op == OP_SM4_ED)     || (sel_op == OP_SM4_KS);

  assign req_ready = (grant_en && !rst) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  // Owner cancel acts in the same cycle, so the registered issue strobe is masked here.
  assign owner_flush = req_flush[owner_q] && (state_q != IDLE);
  assign unit_valid  = unit_valid_q && !owner_flush;
  assign dbg_state   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      bypass_q     <= 1'b0;
      unit_valid_q <= 1'b0;
      unit_op      <= '0;
      unit_rs1     <= '0;
      unit_rs2     <= '0;
      unit_bs      <= '0;
      unit_flush   <= 1'b0;
      resp_valid   <= 2'b00;
      resp_data    <= '0;
    end else begin
      resp_valid   <= 2'b00;
      unit_flush   <= 1'b0;
      unit_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            owner_q      <= grant_id;
            bypass_q     <= !sel_is_crypto;
            unit_valid_q <= sel_is_crypto;
            unit_op      <= sel_op;
            unit_rs1     <= req_rs1[grant_id];
            unit_rs2     <= req_rs2[grant_id];
            unit_bs      <= req_bs[grant_id];
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (owner_flush) begin
            // A bypassed op never reached the unit, so there is nothing to abort.
            unit_flush <= !bypass_q;
            state_q    <= IDLE;
          end else if (bypass_q) begin
            resp_valid <= owner_q ? 2'b10 : 2'b01;
            resp_data  <= '0;
            state_q    <= IDLE;
          end else begin
            state_q <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (owner_flush) begin
            unit_flush <= 1'b1;
            state_q    <= IDLE;
          end else if (unit_result_valid) begin
            resp_data  <= unit_result;
            resp_valid <= owner_q ? 2'b10 : 2'b01;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CRYPTO_ARB_RR_EN
  // Pointer names the requester preferred on the next tie; moves only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           prio_q <= 1'b0;
    else if (grant_en) prio_q <= !grant_id;
  end
`endif

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_ready_idle:    assert property (@(posedge clk) disable iff (rst)
                                    (req_ready != 2'b00) |-> (state_q == IDLE));
  a_unit_issue:    assert property (@(posedge clk) disable iff (rst)
                                    unit_valid |-> (state_q == ISSUE));

endmodule

// File: tb/tb_crypto_arbiter.sv
// Self-checking bench for crypto_arbiter: vector table for single ops, hand sequences for
// contention, flush, collision, busy and reset corners; responses checked via an expected queue.
module tb_crypto_arbiter;
  localparam int DATA_W = 32;
  localparam int W      = DATA_W + 1;

  localparam logic [2:0] OP_DSI = 3'd0, OP_DSMI = 3'd1, OP_ESI = 3'd2, OP_ESMI = 3'd3;
  localparam logic [2:0] OP_ED  = 3'd4, OP_KS   = 3'd5, OP_BAD6 = 3'd6, OP_BAD7 = 3'd7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][2:0]        req_op;
  logic [1:0][DATA_W-1:0] req_rs1;
  logic [1:0][DATA_W-1:0] req_rs2;
  logic [1:0][1:0]        req_bs;
  logic [1:0]             req_flush;
  logic [1:0]             resp_valid;
  logic [DATA_W-1:0]      resp_data;
  logic                   unit_valid;
  logic [2:0]             unit_op;
  logic [DATA_W-1:0]      unit_rs1;
  logic [DATA_W-1:0]      unit_rs2;
  logic [1:0]             unit_bs;
  logic                   unit_busy;
  logic                   unit_result_valid;
  logic [DATA_W-1:0]      unit_result;
  logic                   unit_flush;
  logic [1:0]             dbg_state;

  always #5 clk = ~clk;

  crypto_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_bs(req_bs), .req_flush(req_flush),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .unit_valid(unit_valid), .unit_op(unit_op), .unit_rs1(unit_rs1), .unit_rs2(unit_rs2),
    .unit_bs(unit_bs), .unit_busy(unit_busy), .unit_result_valid(unit_result_valid),
    .unit_result(unit_result), .unit_flush(unit_flush), .dbg_state(dbg_state)
  );

  int total  = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Response monitor: every resp_valid pulse must match the head of the expected queue.
  always begin
    @(negedge clk);
    #2;
    check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    if (resp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL resp_unexpected: got resp_valid=%b data=%h expected no response",
                 resp_valid, resp_data);
      end else begin
        logic [W-1:0] exp_r;
        exp_r = exp_q.pop_front();
        check("resp_onehot", 64'($onehot(resp_valid)), 64'd1);
        check("resp_owner_data", 64'({resp_valid[1], resp_data}), 64'(exp_r));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs;
    req_valid = 2'b00; req_flush = 2'b00; unit_busy = 1'b0;
    unit_result_valid = 1'b0; unit_result = '0;
    req_op = '0; req_rs1 = '0; req_rs2 = '0; req_bs = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [1:0] mask(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  // Drive a request in the current cycle and check the grant.
  task automatic request(input int r, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] bs);
    @(negedge clk);
    req_valid = mask(r);
    req_op[r] = op; req_rs1[r] = a; req_rs2[r] = b; req_bs[r] = bs;
    #1 check("grant", 64'(req_ready), 64'(mask(r)));
  endtask

  // Called in the ISSUE cycle: return the result next cycle, expect resp the one after.
  task automatic complete(input int r, input logic [31:0] data);
    @(negedge clk);
    unit_result_valid = 1'b1; unit_result = data;
    exp_q.push_back({r[0], data});
    @(negedge clk);
    unit_result_valid = 1'b0;
    #1 check("complete_resp", 64'(resp_valid), 64'(mask(r)));
  endtask

  typedef struct {
    int          req;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  bs;
    int          lat;
    logic [31:0] res;
    logic        exp_unit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  logic exp_grant[4];

  initial begin
    vecs[0] = '{0, OP_ESI,  32'h0000_0000, 32'h0000_0063, 2'd0, 3, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A};
    vecs[1] = '{1, OP_KS,   32'hDEAD_BEEF, 32'h0123_4567, 2'd2, 2, 32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF};
    vecs[2] = '{0, OP_DSMI, 32'hFFFF_FFFF, 32'h8000_0001, 2'd3, 6, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{1, OP_BAD7, 32'h1234_5678, 32'h9ABC_DEF0, 2'd1, 0, 32'h0,         1'b0, 32'h0};
    vecs[4] = '{0, OP_BAD6, 32'hCAFE_F00D, 32'h0BAD_CAFE, 2'd2, 0, 32'h0,         1'b0, 32'h0};
    vecs[5] = '{1, OP_DSI,  32'h0000_0001, 32'h0000_0002, 2'd1, 4, 32'h0000_0001, 1'b1, 32'h0000_0001};
`ifdef CRYPTO_ARB_RR_EN
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state, including req_ready gated while reset is held.
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1 check("rst_ready_gated", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data",  64'(resp_data),  64'd0);
    check("rst_unit_fields", 64'({unit_valid, unit_op, unit_bs, unit_flush}), 64'd0);
    check("rst_unit_rs",    64'({unit_rs1, unit_rs2}), 64'd0);
    check("rst_state",      64'(dbg_state),  64'd0);

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      request(v.req, v.op, v.rs1, v.rs2, v.bs);
      exp_q.push_back({v.req[0], v.exp_data});
      @(negedge clk);
      req_valid = 2'b00;
      #1 check("vec_unit_valid", 64'(unit_valid), 64'(v.exp_unit));
      if (v.exp_unit) begin
        check("vec_unit_op",  64'(unit_op),  64'(v.op));
        check("vec_unit_rs1", 64'(unit_rs1), 64'(v.rs1));
        check("vec_unit_rs2", 64'(unit_rs2), 64'(v.rs2));
        check("vec_unit_bs",  64'(unit_bs),  64'(v.bs));
        repeat (v.lat - 2) @(negedge clk);
        @(negedge clk);
        unit_result_valid = 1'b1; unit_result = v.res;
        @(negedge clk);
        unit_result_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      #1 check("vec_resp_valid", 64'(resp_valid), 64'(mask(v.req)));
      check("vec_resp_data", 64'(resp_data), 64'(v.exp_data));
    end

    // Contention: both requesters valid for four back-to-back operations.
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_op[0] = OP_ESMI; req_op[1] = OP_ED;
    req_rs1[0] = 32'hA0; req_rs1[1] = 32'hB1;
    for (int n = 0; n < 4; n++) begin
      int   waited;
      logic g;
      waited = 0;
      #1;
      while (req_ready == 2'b00 && waited < 20) begin
        @(negedge clk); #1; waited++;
      end
      check("contention_grant_seen", 64'(waited < 20), 64'd1);
      g = req_ready[1];
      check("contention_grant_id", 64'(g), 64'(exp_grant[n]));
      exp_q.push_back({g, 32'hC0DE_0000 + 32'(n)});
      @(negedge clk);
      @(negedge clk);
      unit_result_valid = 1'b1; unit_result = 32'hC0DE_0000 + 32'(n);
      @(negedge clk);
      unit_result_valid = 1'b0;
      if (n == 3) req_valid = 2'b00;
    end

    // Owner 1 cancels in WAIT_RESP; requester 0 is granted the following cycle.
    do_reset();
    request(1, OP_ED, 32'h11, 32'h22, 2'd0);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("flw_unit_valid", 64'(unit_valid), 64'd1);
    @(negedge clk);
    req_flush = 2'b10;
    #1 check("flw_no_unit_valid", 64'(unit_valid), 64'd0);
    @(negedge clk);
    req_flush = 2'b00;
    req_valid = 2'b01; req_op[0] = OP_DSI;
    #1;
    check("flw_unit_flush", 64'(unit_flush), 64'd1);
    check("flw_next_grant", 64'(req_ready), 64'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("flw_flush_once", 64'(unit_flush), 64'd0);
    complete(0, 32'h1111_2222);

    // Owner 0 cancels in ISSUE: issue strobe masked, abort follows.
    request(0, OP_KS, 32'h5, 32'h6, 2'd1);
    @(negedge clk);
    req_valid = 2'b00; req_flush = 2'b01;
    #1 check("fli_unit_valid", 64'(unit_valid), 64'd0);
    @(negedge clk);
    req_flush = 2'b00;
    #1;
    check("fli_unit_flush", 64'(unit_flush), 64'd1);
    check("fli_state_idle", 64'(dbg_state), 64'd0);

    // Collision: result and owner flush together -> flush wins, resp_data holds.
    request(0, OP_ESI, 32'h7, 32'h8, 2'd2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    unit_result_valid = 1'b1; unit_result = 32'hBAD0_BAD0; req_flush = 2'b01;
    @(negedge clk);
    unit_result_valid = 1'b0; req_flush = 2'b00;
    #1;
    check("col_no_resp", 64'(resp_valid), 64'd0);
    check("col_unit_flush", 64'(unit_flush), 64'd1);
    check("col_data_held", 64'(resp_data), 64'h1111_2222);

    // Non-owner flush during WAIT_RESP has no effect.
    request(1, OP_DSMI, 32'h9, 32'hA, 2'd3);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    unit_result_valid = 1'b1; unit_result = 32'h600D_600D; req_flush = 2'b01;
    exp_q.push_back({1'b1, 32'h600D_600D});
    @(negedge clk);
    unit_result_valid = 1'b0; req_flush = 2'b00;
    #1;
    check("nof_resp", 64'(resp_valid), 64'b10);
    check("nof_no_flush", 64'(unit_flush), 64'd0);
    check("nof_data", 64'(resp_data), 64'h600D_600D);

    // Flush in IDLE blocks that requester's grant.
    do_reset();
    @(negedge clk);
    req_valid = 2'b11; req_flush = 2'b01; req_op[1] = OP_ED;
    #1 check("idle_flush_block", 64'(req_ready), 64'b10);
    @(negedge clk);
    req_valid = 2'b00; req_flush = 2'b00;
    complete(1, 32'h0F0F_0F0F);

    // Busy unit holds IDLE.
    @(negedge clk);
    unit_busy = 1'b1; req_valid = 2'b01; req_op[0] = OP_ESMI;
    for (int c = 0; c < 3; c++) begin
      #1 check("busy_no_grant", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    unit_busy = 1'b0;
    #1 check("busy_release_grant", 64'(req_ready), 64'b01);
    @(negedge clk);
    req_valid = 2'b00;
    complete(0, 32'h7777_0001);

    // Stray result in IDLE is ignored.
    @(negedge clk);
    unit_result_valid = 1'b1; unit_result = 32'hDEAD_0000;
    @(negedge clk);
    unit_result_valid = 1'b0;
    #1 check("stray_no_resp", 64'(resp_valid), 64'd0);

    // Reset in WAIT_RESP clears everything at once; a late result is ignored.
    request(1, OP_KS, 32'h1357_9BDF, 32'h2468_ACE0, 2'd3);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    check("rstw_ready", 64'(req_ready), 64'd0);
    check("rstw_resp", 64'({resp_valid, resp_data}), 64'd0);
    check("rstw_unit", 64'({unit_valid, unit_op, unit_bs, unit_flush}), 64'd0);
    check("rstw_unit_rs", 64'({unit_rs1, unit_rs2}), 64'd0);
    check("rstw_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    unit_result_valid = 1'b1; unit_result = 32'hFACE_FACE;
    @(negedge clk);
    unit_result_valid = 1'b0;
    #1;
    check("rstw_late_no_resp", 64'(resp_valid), 64'd0);
    check("rstw_late_no_flush", 64'(unit_flush), 64'd0);
    check("rstw_late_data", 64'(resp_data), 64'd0);

    repeat (3) @(negedge clk);
    #3 check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/crypto_arbiter.md
CRYPTO_ARBITER -- requirements
Module: crypto_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  clock, rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port: req_valid  input  2  per-requester request valid; index 0 = pipe 0, index 1 = pipe 1.
REQ-005 SHALL have port: req_ready  output  2  per-requester request accepted this cycle.
REQ-006 SHALL have port: req_op  input  2 x op_t  per-requester crypto op (AES32_DSI/DSMI/ESI/ESMI, SM4_ED/KS).
REQ-007 SHALL have port: req_rs1, req_rs2  input  2 x DATA_W  per-requester operands.
REQ-008 SHALL have port: req_bs  input  2 x 2  per-requester byte select.
REQ-009 SHALL have port: req_flush  input  2  per-requester cancel.
REQ-010 SHALL have port: resp_valid  output  2  one-cycle result pulse to owner.
REQ-011 SHALL have port: resp_data  output  DATA_W  result, shared by both requesters.
REQ-012 SHALL have port: unit_valid  output  1  request to crypto unit.
REQ-013 SHALL have port: unit_op / unit_rs1 / unit_rs2 / unit_bs  output  op_t / DATA_W / DATA_W / 2  registered request fields.
REQ-014 SHALL have port: unit_busy  input  1  crypto unit busy.
REQ-015 SHALL have port: unit_result_valid, unit_result  input  1, DATA_W  unit completion and data.
REQ-016 SHALL have port: unit_flush  output  1  abort to crypto unit.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT_RESP -> IDLE; only one operation is outstanding at a time.
REQ-018 IDLE: if any req_valid, SHALL grant one requester, assert req_ready for that requester for exactly one cycle, capture op/rs1/rs2/bs and owner id, and go to ISSUE.
REQ-019 SHALL never assert req_ready in ISSUE or WAIT_RESP, and never assert both req_ready bits together.
REQ-020 ISSUE: SHALL drive unit_valid=1 for exactly one cycle with the captured fields, then go to WAIT_RESP.
REQ-021 WAIT_RESP: on unit_result_valid, SHALL register unit_result into resp_data, pulse resp_valid[owner] for one cycle on the next cycle, and return to IDLE.
REQ-022 resp_data SHALL hold its value until the next completion.
REQ-023 Latency: from req_valid accepted in IDLE (cycle T), unit_valid is high at T+1; a result at T+k gives resp_valid at T+k+1; earliest new grant is at T+k+1.
REQ-024 req_flush[owner] in ISSUE or WAIT_RESP SHALL suppress unit_valid, pulse unit_flush for one cycle, produce no resp_valid, and return to IDLE.
REQ-025 req_flush of the non-owner SHALL have no effect.
REQ-026 req_flush[i] in IDLE SHALL block the grant to requester i in that cycle.
REQ-027 If unit_result_valid and req_flush[owner] occur in the same cycle, flush SHALL win: result discarded, no resp_valid.
REQ-028 unit_result_valid outside WAIT_RESP SHALL be ignored.
REQ-029 SHALL not grant while unit_busy=1, so IDLE holds.
REQ-030 An op outside the six crypto ops SHALL be granted, then complete without any unit access, with resp_valid[owner]=1 and resp_data=0 two cycles after grant.

Reset
REQ-031 rst SHALL force state=IDLE, priority pointer=0, and the following outputs to 0: req_ready, resp_valid, resp_data, unit_valid, unit_op, unit_rs1, unit_rs2, unit_bs, unit_flush.
REQ-032 rst mid-operation SHALL abandon the operation with no resp_valid and no unit_flush.

Configuration
REQ-033 With CRYPTO_ARB_RR_EN defined, SHALL use round-robin arbitration: on a tie, grant the requester not granted last; pointer updates only on grant.
REQ-034 Without CRYPTO_ARB_RR_EN, SHALL use fixed priority: requester 0 always wins a tie, and no pointer register exists.

Verification
REQ-035 Single request: pipe 0 sends AES32_ESI, rs1=0x00000000, rs2=0x00000063, bs=0; unit returns 0x5A5A5A5A after 3 cycles -> resp_valid[0] fires once and resp_data=0x5A5A5A5A.
REQ-036 Contention: both pipes valid continuously for 4 operations -> with RR_EN grants are 0,1,0,1; without RR_EN grants are 0,0,0,0.
REQ-037 Flush: req_flush[1] in WAIT_RESP for owner 1 -> unit_flush pulses once, no resp_valid, and the next grant occurs the following cycle.
REQ-038 Collision: unit_result_valid and req_flush[owner] in the same cycle -> no resp_valid; req_flush of the non-owner during WAIT_RESP -> result delivered normally.
REQ-039 Reset: assert rst in WAIT_RESP -> all outputs 0 immediately; a late unit_result_valid after reset is ignored.
